// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state type, token constants and CRC7 step function for the SD CMD responder
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT_RSP,
    NCR,
    TX
  } sd_state_e;

  localparam int TOKEN_BITS = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB first.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator with clear and enable
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  // Remainder register; clear takes priority so a new token always starts from zero
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc7_next(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line responder; SD_CMD_CRC_CHECK_EN enables receive CRC7 checking
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR_CYCLES  = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        rsp_valid,
  input  logic        rsp_none,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg,
  input  logic        rsp_nocrc,
  output logic        busy,
  output logic        crc_err,
  output logic        rsp_timeout
);

  localparam int CNT_MAX = (NCR_CYCLES > RSP_TIMEOUT) ? NCR_CYCLES : RSP_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] NCR_L = CW'(NCR_CYCLES);
  localparam logic [CW-1:0] TO_L  = CW'(RSP_TIMEOUT);
  localparam logic [CW-1:0] SAT_L = '1;

  sd_state_e     state_q, state_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [38:0]   rx_sh_q, rx_sh_d;      // token bits [46:8]
  logic          end_ok_q, end_ok_d;
  logic [CW-1:0] since_q, since_d;      // clocks since the command end bit
  logic [39:0]   tx_sh_q, tx_sh_d;      // response bits [47:8]
  logic [5:0]    tx_cnt_q, tx_cnt_d;
  logic          tx_nocrc_q, tx_nocrc_d;
  logic [5:0]    cmd_index_q, cmd_index_d;
  logic [31:0]   cmd_arg_q, cmd_arg_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          crc_err_q, crc_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          tx_crc_clr, tx_crc_en, tx_bit;
  logic [6:0]    tx_crc;
  logic [2:0]    tx_crc_idx;
  logic          cmd_good;

`ifdef SD_CMD_CRC_CHECK_EN
  logic          crc_bad_q, crc_bad_d;
  logic          rx_crc_clr, rx_crc_en;
  logic [6:0]    rx_crc;

  sd_crc7 u_rx_crc (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (rx_crc_clr),
    .en_i    (rx_crc_en),
    .bit_i   (cmd_in),
    .crc_o   (rx_crc)
  );

  assign cmd_good = rx_sh_q[38] & end_ok_q & ~crc_bad_q;
`else
  assign cmd_good = rx_sh_q[38] & end_ok_q;
`endif

  sd_crc7 u_tx_crc (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (tx_crc_clr),
    .en_i    (tx_crc_en),
    .bit_i   (tx_bit),
    .crc_o   (tx_crc)
  );

  // Response bit on the wire: shifted payload, then CRC (or all ones for R3), then end bit
  assign tx_crc_idx = tx_cnt_q[2:0] - 3'd1;
  always_comb begin
    tx_bit = 1'b1;
    if (tx_cnt_q >= 6'd8) begin
      tx_bit = tx_sh_q[39];
    end else if (tx_cnt_q != 6'd0) begin
      tx_bit = tx_nocrc_q ? 1'b1 : tx_crc[tx_crc_idx];
    end
  end

  // Next-state logic for receive, check, response wait, turnaround and transmit
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sh_d       = rx_sh_q;
    end_ok_d      = end_ok_q;
    since_d       = (since_q == SAT_L) ? since_q : since_q + 1'b1;
    tx_sh_d       = tx_sh_q;
    tx_cnt_d      = tx_cnt_q;
    tx_nocrc_d    = tx_nocrc_q;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_valid_d   = 1'b0;
    crc_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    tx_crc_clr    = 1'b0;
    tx_crc_en     = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
    crc_bad_d     = crc_bad_q;
    rx_crc_clr    = 1'b0;
    rx_crc_en     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef SD_CMD_CRC_CHECK_EN
        rx_crc_clr = 1'b1;
        crc_bad_d  = 1'b0;
`endif
        // The start bit is zero, so skipping it leaves a zero-seeded CRC unchanged
        if (!cmd_in) begin
          state_d   = RX;
          bit_cnt_d = 6'(TOKEN_BITS - 2);
        end
      end
      RX: begin
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q >= 6'd8) begin
          rx_sh_d = {rx_sh_q[37:0], cmd_in};
`ifdef SD_CMD_CRC_CHECK_EN
          rx_crc_en = 1'b1;
        end else if (bit_cnt_q != 6'd0 && cmd_in != rx_crc[bit_cnt_q[2:0] - 3'd1]) begin
          crc_bad_d = 1'b1;
`endif
        end
        if (bit_cnt_q == 6'd0) begin
          end_ok_d = cmd_in;
          since_d  = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (cmd_good) begin
          cmd_index_d = rx_sh_q[37:32];
          cmd_arg_d   = rx_sh_q[31:0];
          cmd_valid_d = 1'b1;
          state_d     = WAIT_RSP;
        end else begin
          crc_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_none) begin
            state_d = IDLE;
          end else begin
            tx_sh_d    = {2'b00, rsp_index, rsp_arg};
            tx_nocrc_d = rsp_nocrc;
            tx_crc_clr = 1'b1;
            state_d    = NCR;
          end
        end else if (since_q == TO_L) begin
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      NCR: begin
        // Always at least one clock here, longer only if the response came early
        if (since_q >= NCR_L) begin
          tx_cnt_d = 6'(TOKEN_BITS - 1);
          state_d  = TX;
        end
      end
      TX: begin
        tx_cnt_d = tx_cnt_q - 6'd1;
        if (tx_cnt_q >= 6'd8) begin
          tx_sh_d   = {tx_sh_q[38:0], 1'b0};
          tx_crc_en = 1'b1;
        end
        if (tx_cnt_q == 6'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_sh_q       <= '0;
      end_ok_q      <= 1'b0;
      since_q       <= '0;
      tx_sh_q       <= '0;
      tx_cnt_q      <= '0;
      tx_nocrc_q    <= 1'b0;
      cmd_index_q   <= '0;
      cmd_arg_q     <= '0;
      cmd_valid_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
      crc_bad_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sh_q       <= rx_sh_d;
      end_ok_q      <= end_ok_d;
      since_q       <= since_d;
      tx_sh_q       <= tx_sh_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_nocrc_q    <= tx_nocrc_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
      cmd_valid_q   <= cmd_valid_d;
      crc_err_q     <= crc_err_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef SD_CMD_CRC_CHECK_EN
      crc_bad_q     <= crc_bad_d;
`endif
    end
  end

  assign cmd_oe      = (state_q == NCR) || (state_q == TX);
  assign cmd_out     = (state_q == TX) ? tx_bit : 1'b1;
  assign busy        = (state_q != IDLE);
  assign cmd_valid   = cmd_valid_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;
  assign crc_err     = crc_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb/tb_sd_cmd_responder.sv - self-checking bench for sd_cmd_responder
module tb_sd_cmd_responder;

  localparam int NCR_C = 2;
  localparam int TO_C  = 64;
`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_in;
  logic        cmd_out, cmd_oe, cmd_valid, busy, crc_err, rsp_timeout;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        rsp_valid, rsp_none, rsp_nocrc;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;

  sd_cmd_responder #(.NCR_CYCLES(NCR_C), .RSP_TIMEOUT(TO_C)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_none(rsp_none), .rsp_index(rsp_index), .rsp_arg(rsp_arg),
    .rsp_nocrc(rsp_nocrc), .busy(busy), .crc_err(crc_err), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // CRC7 as the polynomial remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] host_token(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] rsp_token(input logic [5:0] idx, input logic [31:0] arg, input bit nocrc);
    return {2'b00, idx, arg, nocrc ? 7'h7F : ref_crc7({2'b00, idx, arg}), 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [47:0] tok);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_in = tok[i];
    end
  endtask

  // One command/response exchange; reset_at >= 0 asserts reset at that TX bit
  task automatic run_txn(input logic [47:0] tok, input bit exp_good, input logic [5:0] eidx,
                         input logic [31:0] earg, input bit none, input logic [5:0] ridx,
                         input logic [31:0] rarg, input bit nocrc, input logic [47:0] exp_rsp,
                         input int delay, input bit noise, input int reset_at);
    int n;
    int guard;
    int exp_start;
    logic [47:0] got;
    bit oe_ok, stray, oe_seen;
    send_bits(tok);
    @(negedge clk);
    cmd_in = 1'b1;
    check("busy_in_check", busy, 1);
    @(negedge clk);
    n = 1;
    check("cmd_valid", cmd_valid, exp_good);
    check("crc_err", crc_err, !exp_good);
    if (exp_good) begin
      last_idx = eidx;
      last_arg = earg;
    end
    check("cmd_index", cmd_index, last_idx);
    check("cmd_arg", cmd_arg, last_arg);
    if (!exp_good) begin
      check("busy_after_bad", busy, 0);
      return;
    end
    repeat (delay) begin
      @(negedge clk);
      n++;
    end
    rsp_valid = 1'b1; rsp_none = none; rsp_index = ridx; rsp_arg = rarg; rsp_nocrc = nocrc;
    @(negedge clk);
    n++;
    rsp_valid = 1'b0;
    check("cmd_valid_pulse", cmd_valid, 0);
    if (none) begin
      check("busy_after_none", busy, 0);
      oe_seen = cmd_oe;
      repeat (4) begin
        @(negedge clk);
        oe_seen |= cmd_oe;
      end
      check("oe_never_rises", oe_seen, 0);
      return;
    end
    check("ncr_hold", {cmd_oe, cmd_out}, 2'b11);
    guard = 0;
    while (!(cmd_oe && !cmd_out) && guard < 100) begin
      @(negedge clk);
      n++;
      guard++;
    end
    if (guard >= 100) begin
      check("start_bit_timeout", 0, 1);
      return;
    end
    exp_start = (NCR_C + 1 > 3 + delay) ? NCR_C + 1 : 3 + delay;
    check("start_bit_time", n, exp_start);
    oe_ok = 1'b1;
    stray = 1'b0;
    for (int b = 47; b >= 0; b--) begin
      got[b] = cmd_out;
      oe_ok &= cmd_oe;
      stray |= cmd_valid | crc_err;
      cmd_in = (noise && b > 6) ? 1'($urandom) : 1'b1;
      if (reset_at >= 0 && (47 - b) == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("reset_oe", cmd_oe, 0);
        check("reset_out", cmd_out, 1);
        check("reset_busy", busy, 0);
        check("reset_index", cmd_index, 0);
        reset = 1'b0;
        last_idx = '0;
        last_arg = '0;
        return;
      end
      if (b > 0) @(negedge clk);
    end
    check("rsp_token", got, exp_rsp);
    check("oe_during_tx", oe_ok, 1);
    check("no_stray_rx", stray, 0);
    @(negedge clk);
    check("oe_after_tx", cmd_oe, 0);
    check("busy_after_tx", busy, 0);
  endtask

  typedef struct {
    logic [47:0] tok;
    bit          good_chk;
    bit          good_nochk;
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          none;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    bit          nocrc;
    logic [47:0] rsp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    bit g;
    logic [5:0] ci;
    logic [31:0] ca;
    int c;
    logic [47:0] tok;

    vecs[0] = '{48'h400000000095, 1, 1, 6'd0,  32'h0,        1, 6'd0,  32'h0,        0, 48'h0};
    vecs[1] = '{48'h48000001AA87, 1, 1, 6'd8,  32'h1AA,      0, 6'd8,  32'h1AA,      0, 48'h08000001AA13};
    vecs[2] = '{48'h770000000067, 0, 1, 6'd55, 32'h0,        1, 6'd0,  32'h0,        0, 48'h0};
    vecs[3] = '{host_token(6'd41, 32'h40FF8000), 1, 1, 6'd41, 32'h40FF8000,
                0, 6'h3F, 32'h80FF8000, 1, 48'h3F80FF8000FF};
    vecs[4] = '{48'h000000000095, 0, 0, 6'd0,  32'h0,        1, 6'd0,  32'h0,        0, 48'h0};
    vecs[5] = '{48'h400000000094, 0, 0, 6'd0,  32'h0,        1, 6'd0,  32'h0,        0, 48'h0};
    vecs[6] = '{48'h770000000065, 1, 1, 6'd55, 32'h0,        0, 6'd55, 32'h120,      0,
                rsp_token(6'd55, 32'h120, 0)};

    reset = 1'b1; cmd_in = 1'b1;
    rsp_valid = 1'b0; rsp_none = 1'b0; rsp_index = '0; rsp_arg = '0; rsp_nocrc = 1'b0;
    last_idx = '0; last_arg = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_out", cmd_out, 1);
    check("rst_cmd_oe", cmd_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {cmd_valid, crc_err, rsp_timeout}, 3'b000);
    check("rst_index", cmd_index, 0);
    check("rst_arg", cmd_arg, 0);

    foreach (vecs[i]) begin
      g = CRC_CHK ? vecs[i].good_chk : vecs[i].good_nochk;
      run_txn(vecs[i].tok, g, vecs[i].idx, vecs[i].arg, vecs[i].none, vecs[i].ridx,
              vecs[i].rarg, vecs[i].nocrc, vecs[i].rsp, 0, 0, -1);
    end

    // Response timeout followed by an accepted CMD0
    send_bits(48'h48000001AA87);
    @(negedge clk);
    cmd_in = 1'b1;
    @(negedge clk);
    n = 1;
    check("to_cmd_valid", cmd_valid, 1);
    while (!rsp_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_time", n, 1 + TO_C);
    check("to_busy", busy, 0);
    @(negedge clk);
    check("to_pulse", rsp_timeout, 0);
    last_idx = 6'd8; last_arg = 32'h1AA;
    run_txn(48'h400000000095, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0, 0, 48'h0, 0, 0, -1);

    // Reset during TX bit 20, then a clean CMD8 exchange
    run_txn(48'h48000001AA87, 1, 6'd8, 32'h1AA, 0, 6'd8, 32'h1AA, 0, 48'h08000001AA13, 0, 0, 20);
    run_txn(48'h48000001AA87, 1, 6'd8, 32'h1AA, 0, 6'd8, 32'h1AA, 0, 48'h08000001AA13, 0, 0, -1);

    // Randomized exchanges against the reference model
    for (int k = 0; k < 30; k++) begin
      ci  = 6'($urandom);
      ca  = $urandom;
      c   = $urandom_range(0, 5);
      tok = host_token(ci, ca);
      if (c == 3) tok[$urandom_range(1, 7)] ^= 1'b1;
      if (c == 4) tok[46] = 1'b0;
      if (c == 5) tok[0] = 1'b0;
      g = !(c == 4 || c == 5 || (c == 3 && CRC_CHK));
      begin
        logic [5:0]  ri;
        logic [31:0] ra;
        bit          nc;
        ri = 6'($urandom);
        ra = $urandom;
        nc = 1'($urandom);
        run_txn(tok, g, ci, ca, ($urandom_range(0, 3) == 0), ri, ra, nc, rsp_token(ri, ra, nc),
                $urandom_range(0, 5), 1'($urandom), -1);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
